crc16_rx_chk: RTL and testbench

- Receive-path stage directly downstream of the byte-level rx framer (sop/eop/valid/data stream).
- Accepts whole USB DATA packets: PID, payload, CRC16.
- Validates the PID, strips PID and CRC bytes, and forwards the payload to the link layer with clean sop/eop framing.
- Computes USB CRC16 on the payload and reports CRC, PID and length status once per packet.

---
 rtl/crc16_rx_chk.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_crc16_rx_chk.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc16_rx_chk.sv
// crc16_rx_chk: receive-side checker for USB DATA packets (PID, payload, CRC16).
// Validates the PID, strips the PID and the two CRC bytes through a two-byte
// holdback window, forwards the payload with clean sop/eop framing and reports
// CRC/PID/length status with a one-cycle pkt_done pulse.
// Optional feature: define CRC16_RX_CHK_ERR_CNT_EN to add o_crc16_rx_chk_err_cnt,
// a saturating count of packets completed with a CRC error.
module crc16_rx_chk #(
  parameter int MAX_PAYLOAD = 1024,
  parameter int LEN_W       = 11
) (
  input  logic             i_crc16_rx_chk_clk,
  input  logic             i_crc16_rx_chk_rst_n,
  input  logic             i_crc16_rx_chk_rx_sop,
  input  logic             i_crc16_rx_chk_rx_eop,
  input  logic             i_crc16_rx_chk_rx_valid,
  input  logic [7:0]       i_crc16_rx_chk_rx_data,
  output logic             o_crc16_rx_chk_pl_sop,
  output logic             o_crc16_rx_chk_pl_eop,
  output logic             o_crc16_rx_chk_pl_valid,
  output logic [7:0]       o_crc16_rx_chk_pl_data,
  output logic [3:0]       o_crc16_rx_chk_pid,
  output logic             o_crc16_rx_chk_pkt_done,
  output logic             o_crc16_rx_chk_crc16_error,
  output logic             o_crc16_rx_chk_pid_error,
  output logic             o_crc16_rx_chk_len_error,
  output logic [LEN_W-1:0] o_crc16_rx_chk_pl_len
`ifdef CRC16_RX_CHK_ERR_CNT_EN
  ,
  output logic [15:0]      o_crc16_rx_chk_err_cnt
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PAYLOAD);

  // One input bit at a time: reflected USB CRC16, polynomial 0xA001.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                             input logic [7:0]  byte_in);
    logic [15:0] c;
    logic        fb;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ byte_in[i];
      c  = {1'b0, c[15:1]};
      c  = fb ? (c ^ 16'hA001) : c;
    end
    return c;
  endfunction

  // DATA0/DATA1/DATA2/MDATA with a consistent check nibble.
  function automatic logic pid_is_data(input logic [7:0] pid_byte);
    logic chk_ok;
    logic res;
    chk_ok = (pid_byte[7:4] == ~pid_byte[3:0]);
    case (pid_byte)
      8'hC3, 8'h4B, 8'h87, 8'h0F: res = chk_ok;
      default:                    res = 1'b0;
    endcase
    return res;
  endfunction

  logic       clk;
  logic       rst_n;
  logic       rx_sop;
  logic       rx_eop;
  logic       rx_valid;
  logic [7:0] rx_data;

  assign clk      = i_crc16_rx_chk_clk;
  assign rst_n    = i_crc16_rx_chk_rst_n;
  assign rx_sop   = i_crc16_rx_chk_rx_sop;
  assign rx_eop   = i_crc16_rx_chk_rx_eop;
  assign rx_valid = i_crc16_rx_chk_rx_valid;
  assign rx_data  = i_crc16_rx_chk_rx_data;

  logic [1:0]       state_q,    state_d;
  logic [7:0]       win0_q,     win0_d;      // oldest held byte
  logic [7:0]       win1_q,     win1_d;      // newest held byte
  logic [1:0]       wcnt_q,     wcnt_d;
  logic [15:0]      crc_q,      crc_d;
  logic             pend_pid_q, pend_pid_d;
  logic             pend_len_q, pend_len_d;
  logic             pl_sop_q,   pl_sop_d;
  logic             pl_eop_q,   pl_eop_d;
  logic             pl_valid_q, pl_valid_d;
  logic [7:0]       pl_data_q,  pl_data_d;
  logic [3:0]       pid_q,      pid_d;
  logic             pkt_done_q, pkt_done_d;
  logic             crc_err_q,  crc_err_d;
  logic             pid_err_q,  pid_err_d;
  logic             len_err_q,  len_err_d;
  logic [LEN_W-1:0] pl_len_q,   pl_len_d;

  logic [15:0] crc_upd;
  logic        pid_ok;

  assign crc_upd = crc16_byte(crc_q, win0_q);
  assign pid_ok  = pid_is_data(rx_data);

  // Packet FSM, holdback window, CRC accumulation and status generation.
  always_comb begin
    state_d    = state_q;
    win0_d     = win0_q;
    win1_d     = win1_q;
    wcnt_d     = wcnt_q;
    crc_d      = crc_q;
    pend_pid_d = pend_pid_q;
    pend_len_d = pend_len_q;
    pl_sop_d   = 1'b0;
    pl_eop_d   = 1'b0;
    pl_valid_d = 1'b0;
    pl_data_d  = pl_data_q;
    pid_d      = pid_q;
    pkt_done_d = 1'b0;
    crc_err_d  = 1'b0;
    pid_err_d  = 1'b0;
    len_err_d  = 1'b0;
    pl_len_d   = pl_len_q;
    if (rx_valid) begin
      if (rx_sop) begin
        // A sop outside IDLE aborts the packet in flight; the new PID is
        // still taken in this same cycle.
        if (state_q != ST_IDLE) begin
          pkt_done_d = 1'b1;
          len_err_d  = 1'b1;
          pid_err_d  = pend_pid_q;
        end else begin
          pkt_done_d = 1'b0;
        end
        pid_d      = rx_data[3:0];
        pl_len_d   = '0;
        wcnt_d     = 2'd0;
        crc_d      = 16'hFFFF;
        pend_pid_d = ~pid_ok;
        pend_len_d = 1'b0;
        if (rx_eop) begin
          pkt_done_d = 1'b1;
          len_err_d  = 1'b1;
          pid_err_d  = pid_err_d | ~pid_ok;
          state_d    = ST_IDLE;
        end else if (pid_ok) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_DROP;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_d = ST_IDLE;
          end
          ST_DATA: begin
            if (wcnt_q == 2'd2) begin
              if (pl_len_q == MAX_LEN) begin
                // Emitting the held byte would overrun MAX_PAYLOAD.
                if (rx_eop) begin
                  pkt_done_d = 1'b1;
                  len_err_d  = 1'b1;
                  state_d    = ST_IDLE;
                end else begin
                  pend_len_d = 1'b1;
                  state_d    = ST_DROP;
                end
              end else begin
                pl_valid_d = 1'b1;
                pl_data_d  = win0_q;
                pl_sop_d   = (pl_len_q == '0);
                pl_len_d   = pl_len_q + LEN_W'(1);
                crc_d      = crc_upd;
                win0_d     = win1_q;
                win1_d     = rx_data;
                if (rx_eop) begin
                  // CRC field arrives low byte first: win1 is low, eop byte high.
                  pl_eop_d   = 1'b1;
                  pkt_done_d = 1'b1;
                  crc_err_d  = ({rx_data, win1_q} != ~crc_upd);
                  wcnt_d     = 2'd0;
                  state_d    = ST_IDLE;
                end else begin
                  wcnt_d = 2'd2;
                end
              end
            end else if (wcnt_q == 2'd1) begin
              if (rx_eop) begin
                // Zero-length payload: the two bytes are the CRC of nothing.
                pkt_done_d = 1'b1;
                crc_err_d  = ({rx_data, win0_q} != ~crc_q);
                wcnt_d     = 2'd0;
                state_d    = ST_IDLE;
              end else begin
                win1_d = rx_data;
                wcnt_d = 2'd2;
              end
            end else begin
              if (rx_eop) begin
                pkt_done_d = 1'b1;
                len_err_d  = 1'b1;
                state_d    = ST_IDLE;
              end else begin
                win0_d = rx_data;
                wcnt_d = 2'd1;
              end
            end
          end
          ST_DROP: begin
            if (rx_eop) begin
              pkt_done_d = 1'b1;
              pid_err_d  = pend_pid_q;
              len_err_d  = pend_len_q;
              state_d    = ST_IDLE;
            end else begin
              state_d = ST_DROP;
            end
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      win0_q     <= 8'h00;
      win1_q     <= 8'h00;
      wcnt_q     <= 2'd0;
      crc_q      <= 16'hFFFF;
      pend_pid_q <= 1'b0;
      pend_len_q <= 1'b0;
      pl_sop_q   <= 1'b0;
      pl_eop_q   <= 1'b0;
      pl_valid_q <= 1'b0;
      pl_data_q  <= 8'h00;
      pid_q      <= 4'h0;
      pkt_done_q <= 1'b0;
      crc_err_q  <= 1'b0;
      pid_err_q  <= 1'b0;
      len_err_q  <= 1'b0;
      pl_len_q   <= '0;
    end else begin
      state_q    <= state_d;
      win0_q     <= win0_d;
      win1_q     <= win1_d;
      wcnt_q     <= wcnt_d;
      crc_q      <= crc_d;
      pend_pid_q <= pend_pid_d;
      pend_len_q <= pend_len_d;
      pl_sop_q   <= pl_sop_d;
      pl_eop_q   <= pl_eop_d;
      pl_valid_q <= pl_valid_d;
      pl_data_q  <= pl_data_d;
      pid_q      <= pid_d;
      pkt_done_q <= pkt_done_d;
      crc_err_q  <= crc_err_d;
      pid_err_q  <= pid_err_d;
      len_err_q  <= len_err_d;
      pl_len_q   <= pl_len_d;
    end
  end

  assign o_crc16_rx_chk_pl_sop      = pl_sop_q;
  assign o_crc16_rx_chk_pl_eop      = pl_eop_q;
  assign o_crc16_rx_chk_pl_valid    = pl_valid_q;
  assign o_crc16_rx_chk_pl_data     = pl_data_q;
  assign o_crc16_rx_chk_pid         = pid_q;
  assign o_crc16_rx_chk_pkt_done    = pkt_done_q;
  assign o_crc16_rx_chk_crc16_error = crc_err_q;
  assign o_crc16_rx_chk_pid_error   = pid_err_q;
  assign o_crc16_rx_chk_len_error   = len_err_q;
  assign o_crc16_rx_chk_pl_len      = pl_len_q;

`ifdef CRC16_RX_CHK_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Saturating count of completed packets that failed the CRC check.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (pkt_done_q && crc_err_q && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Error counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 16'h0000;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_crc16_rx_chk_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_crc16_rx_chk.sv
// Bench for crc16_rx_chk: two instances (default MAX_PAYLOAD and MAX_PAYLOAD=4)
// fed the same byte stream; a packet-level model predicts payload bytes and
// per-packet status, and one monitor compares both instances every cycle.
module tb_crc16_rx_chk;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [7:0] d;
    logic       s;
    logic       e;
  } pl_t;
  typedef struct {
    logic       crc;
    logic       pe;
    logic       le;
    logic [3:0] pid;
    int         len;
    int         cyc;
  } st_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic       rx_sop   = 1'b0;
  logic       rx_eop   = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data  = 8'h00;

  logic [1:0]       pl_sop, pl_eop, pl_valid, pkt_done, crc_e, pid_e, len_e;
  logic [1:0][7:0]  pl_data;
  logic [1:0][3:0]  pid;
  logic [1:0][10:0] pl_len;
`ifdef CRC16_RX_CHK_ERR_CNT_EN
  logic [1:0][15:0] err_cnt;
`endif

  int   maxp[2] = '{1024, 4};
  pl_t  exp_pl[2][$];
  st_t  exp_st[2][$];
  st_t  abort_st[2];
  st_t  term_st[2];
  bit   abort_pend = 1'b0;
  bit   term_arm   = 1'b0;
  bit   mon_en     = 1'b0;
  int   tot_crc[2] = '{0, 0};
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  crc16_rx_chk u_dut0 (
    .i_crc16_rx_chk_clk(clk), .i_crc16_rx_chk_rst_n(rst_n),
    .i_crc16_rx_chk_rx_sop(rx_sop), .i_crc16_rx_chk_rx_eop(rx_eop),
    .i_crc16_rx_chk_rx_valid(rx_valid), .i_crc16_rx_chk_rx_data(rx_data),
    .o_crc16_rx_chk_pl_sop(pl_sop[0]), .o_crc16_rx_chk_pl_eop(pl_eop[0]),
    .o_crc16_rx_chk_pl_valid(pl_valid[0]), .o_crc16_rx_chk_pl_data(pl_data[0]),
    .o_crc16_rx_chk_pid(pid[0]), .o_crc16_rx_chk_pkt_done(pkt_done[0]),
    .o_crc16_rx_chk_crc16_error(crc_e[0]), .o_crc16_rx_chk_pid_error(pid_e[0]),
    .o_crc16_rx_chk_len_error(len_e[0]), .o_crc16_rx_chk_pl_len(pl_len[0])
`ifdef CRC16_RX_CHK_ERR_CNT_EN
    , .o_crc16_rx_chk_err_cnt(err_cnt[0])
`endif
  );

  crc16_rx_chk #(.MAX_PAYLOAD(4), .LEN_W(11)) u_dut1 (
    .i_crc16_rx_chk_clk(clk), .i_crc16_rx_chk_rst_n(rst_n),
    .i_crc16_rx_chk_rx_sop(rx_sop), .i_crc16_rx_chk_rx_eop(rx_eop),
    .i_crc16_rx_chk_rx_valid(rx_valid), .i_crc16_rx_chk_rx_data(rx_data),
    .o_crc16_rx_chk_pl_sop(pl_sop[1]), .o_crc16_rx_chk_pl_eop(pl_eop[1]),
    .o_crc16_rx_chk_pl_valid(pl_valid[1]), .o_crc16_rx_chk_pl_data(pl_data[1]),
    .o_crc16_rx_chk_pid(pid[1]), .o_crc16_rx_chk_pkt_done(pkt_done[1]),
    .o_crc16_rx_chk_crc16_error(crc_e[1]), .o_crc16_rx_chk_pid_error(pid_e[1]),
    .o_crc16_rx_chk_len_error(len_e[1]), .o_crc16_rx_chk_pl_len(pl_len[1])
`ifdef CRC16_RX_CHK_ERR_CNT_EN
    , .o_crc16_rx_chk_err_cnt(err_cnt[1])
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  // Reference CRC straight from the bit-serial definition.
  function automatic logic [15:0] crc_model(input bq_t b);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (b[i]) begin
      for (int j = 0; j < 8; j++) begin
        if (c[0] ^ b[i][j]) c = (c >> 1) ^ 16'hA001;
        else                c = c >> 1;
      end
    end
    return c;
  endfunction

  // Whole-packet prediction: payload bytes that must appear and the status.
  function automatic st_t model(input bq_t pkt, input bit aborted, input int k, input bit push);
    st_t        st;
    bq_t        pay;
    pl_t        e;
    int         n;
    int         nout;
    logic [7:0] p;
    logic       ok;
    p  = pkt[0];
    ok = (p == 8'hC3) || (p == 8'h4B) || (p == 8'h87) || (p == 8'h0F);
    n  = pkt.size() - 1;
    st.crc = 1'b0; st.pe = ~ok; st.le = 1'b0; st.pid = p[3:0]; st.len = 0; st.cyc = 0;
    nout = 0;
    if (aborted) begin
      st.le = 1'b1;
      if (ok && n > 2) nout = n - 2;
      if (nout > maxp[k]) nout = maxp[k];
    end else if (n == 0) begin
      st.le = 1'b1;
    end else if (ok) begin
      if (n < 2) begin
        st.le = 1'b1;
      end else if (n - 2 > maxp[k]) begin
        st.le = 1'b1; nout = maxp[k]; st.len = maxp[k];
      end else begin
        nout = n - 2; st.len = n - 2;
        for (int i = 1; i <= n - 2; i++) pay.push_back(pkt[i]);
        st.crc = ((crc_model(pay) ^ 16'hFFFF) != {pkt[n], pkt[n-1]});
      end
    end
    if (push) begin
      for (int i = 0; i < nout; i++) begin
        e.d = pkt[i+1];
        e.s = (i == 0);
        e.e = (!aborted && !st.le && (i == nout - 1));
        exp_pl[k].push_back(e);
      end
    end
    return st;
  endfunction

  task automatic send_byte(input logic s, input logic e, input logic [7:0] d, input int gap);
    int g;
    g = (gap == 0) ? 0 : int'($urandom_range(gap, 0));
    for (int i = 0; i < g; i++) begin
      rx_valid = 1'b0;
      rx_sop   = 1'($urandom_range(1, 0));
      rx_eop   = 1'($urandom_range(1, 0));
      rx_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    rx_valid = 1'b1; rx_sop = s; rx_eop = e; rx_data = d;
    if (term_arm) begin
      for (int k = 0; k < 2; k++) begin
        term_st[k].cyc = cyc + 1;
        exp_st[k].push_back(term_st[k]);
        tot_crc[k] += int'(term_st[k].crc);
      end
      term_arm = 1'b0;
    end
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
  endtask

  // aborted: no eop, the next packet's sop ends it; rst_mid: reset after the bytes.
  task automatic send_pkt(input bq_t pkt, input bit aborted, input bit rst_mid, input int gap);
    st_t st[2];
    for (int k = 0; k < 2; k++) st[k] = model(pkt, aborted | rst_mid, k, 1'b1);
    for (int i = 0; i < pkt.size(); i++) begin
      if (i == 0 && abort_pend) begin
        for (int k = 0; k < 2; k++) begin
          abort_st[k].pid = pkt[0][3:0];
          term_st[k] = abort_st[k];
        end
        term_arm = 1'b1; abort_pend = 1'b0;
      end
      if (!aborted && !rst_mid && i == pkt.size() - 1) begin
        term_st = st; term_arm = 1'b1;
      end
      send_byte(i == 0, !aborted && !rst_mid && (i == pkt.size() - 1), pkt[i], gap);
    end
    if (aborted) begin
      abort_st = st; abort_pend = 1'b1;
    end
    if (rst_mid) begin
      @(negedge clk); #1; rst_n = 1'b0;
      @(posedge clk); #1; rst_n = 1'b1;
    end
  endtask

  function automatic bq_t mk_pkt(input logic [7:0] p, input bq_t pay, input bit bad_crc);
    bq_t        q;
    logic [15:0] c;
    q = pay;
    q.push_front(p);
    c = crc_model(pay) ^ 16'hFFFF;
    q.push_back(c[7:0]);
    q.push_back(bad_crc ? (c[15:8] ^ 8'h01) : c[15:8]);
    return q;
  endfunction

  // Per-cycle comparison of both instances against the model queues.
  always @(negedge clk) begin
    pl_t e;
    st_t s;
    if (mon_en) begin
      for (int k = 0; k < 2; k++) begin
        if (pl_valid[k]) begin
          if (exp_pl[k].size() == 0) begin
            chk($sformatf("dut%0d_pl_unexpected", k), 32'(pl_valid[k]), 32'(0));
          end else begin
            e = exp_pl[k].pop_front();
            chk($sformatf("dut%0d_pl_data", k), 32'(pl_data[k]), 32'(e.d));
            chk($sformatf("dut%0d_pl_sop", k), 32'(pl_sop[k]), 32'(e.s));
            chk($sformatf("dut%0d_pl_eop", k), 32'(pl_eop[k]), 32'(e.e));
          end
        end else begin
          chk($sformatf("dut%0d_strobes_idle", k), 32'({pl_sop[k], pl_eop[k]}), 32'(0));
        end
        if (pkt_done[k]) begin
          if (exp_st[k].size() == 0) begin
            chk($sformatf("dut%0d_done_unexpected", k), 32'(pkt_done[k]), 32'(0));
          end else begin
            s = exp_st[k].pop_front();
            chk($sformatf("dut%0d_done_cycle", k), 32'(cyc), 32'(s.cyc));
            chk($sformatf("dut%0d_crc_err", k), 32'(crc_e[k]), 32'(s.crc));
            chk($sformatf("dut%0d_pid_err", k), 32'(pid_e[k]), 32'(s.pe));
            chk($sformatf("dut%0d_len_err", k), 32'(len_e[k]), 32'(s.le));
            chk($sformatf("dut%0d_pid", k), 32'(pid[k]), 32'(s.pid));
            chk($sformatf("dut%0d_pl_len", k), 32'(pl_len[k]), 32'(s.len));
          end
        end else begin
          chk($sformatf("dut%0d_flags_idle", k), 32'({crc_e[k], pid_e[k], len_e[k]}), 32'(0));
        end
      end
    end
  end

  initial begin
    bq_t  pay;
    bq_t  p;
    st_t  st;
    int   kind;
    int   len;
    logic [7:0] pidb;
    logic [7:0] pids[4];
    pids = '{8'hC3, 8'h4B, 8'h87, 8'h0F};

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dut%0d_rst_strobes", k),
          32'({pl_sop[k], pl_eop[k], pl_valid[k], pkt_done[k], crc_e[k], pid_e[k], len_e[k]}), 32'(0));
      chk($sformatf("dut%0d_rst_data", k), 32'({pl_data[k], pid[k], pl_len[k]}), 32'(0));
    end

    // Pin the model against hand-derived values.
    pay = {};
    for (int i = 1; i <= 9; i++) pay.push_back(8'(8'h30 + i));
    chk("pin_crc_123456789", 32'(crc_model(pay) ^ 16'hFFFF), 32'(16'hB4C8));
    p = mk_pkt(8'h4B, pay, 1'b0);
    chk("pin_crc_bytes", 32'({p[10], p[11]}), 32'(16'hC8B4));
    st = model(p, 1'b0, 0, 1'b0);
    chk("pin_good_pkt", 32'({st.crc, st.pe, st.le, st.pid}), 32'(4'hB));
    chk("pin_good_len", 32'(st.len), 32'(9));
    p[11] = 8'hB5;
    st = model(p, 1'b0, 0, 1'b0);
    chk("pin_bad_crc", 32'(st.crc), 32'(1));
    st = model({8'h87, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00, 8'h00}, 1'b0, 1, 1'b0);
    chk("pin_overlong", 32'({st.le, st.crc}), 32'(2'b10));
    chk("pin_overlong_len", 32'(st.len), 32'(4));
    st = model({8'hC2, 8'h00, 8'h00}, 1'b0, 0, 1'b0);
    chk("pin_bad_pid", 32'({st.pe, st.le}), 32'(2'b10));

    rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Directed packets.
    send_pkt({8'hC3, 8'h00, 8'h00}, 1'b0, 1'b0, 0);
    p = mk_pkt(8'h4B, pay, 1'b0);
    send_pkt(p, 1'b0, 1'b0, 0);
    send_pkt(p, 1'b0, 1'b0, 3);
    p[11] = 8'hB5;
    send_pkt(p, 1'b0, 1'b0, 0);
    send_pkt({8'hC2, 8'h00, 8'h00}, 1'b0, 1'b0, 0);
    send_pkt({8'h4B, 8'h00}, 1'b0, 1'b0, 0);
    send_pkt(mk_pkt(8'h87, {8'h01, 8'h02, 8'h03, 8'h04, 8'h05}, 1'b0), 1'b0, 1'b0, 0);
    send_pkt(mk_pkt(8'h87, {8'h01, 8'h02, 8'h03, 8'h04}, 1'b0), 1'b0, 1'b0, 1);
    send_pkt({8'hC3, 8'hAA, 8'hBB}, 1'b1, 1'b0, 0);
    send_pkt({8'h4B, 8'h00, 8'h00}, 1'b0, 1'b0, 0);
    send_pkt({8'h4B, 8'h11, 8'h22, 8'h33, 8'h44}, 1'b0, 1'b1, 0);
    send_pkt({8'hE1}, 1'b0, 1'b0, 0);

    // Randomized packets.
    for (int t = 0; t < 300; t++) begin
      kind = int'($urandom_range(9, 0));
      len  = int'($urandom_range(8, 0));
      pay  = {};
      for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
      pidb = (kind == 0) ? 8'($urandom) : pids[$urandom_range(3, 0)];
      p = mk_pkt(pidb, pay, kind == 1);
      if (kind == 2) begin
        while (p.size() > ((abort_pend || $urandom_range(1, 0) == 1) ? 2 : 1)) void'(p.pop_back());
      end
      if (kind == 4 && !abort_pend) begin
        send_byte(1'b0, 1'($urandom_range(1, 0)), 8'($urandom), 1);
        send_byte(1'b0, 1'b0, 8'($urandom), 1);
      end
      send_pkt(p, kind == 3, kind == 5 && !abort_pend && t % 3 == 0, int'($urandom_range(2, 0)));
    end
    if (abort_pend) send_pkt({8'h0F, 8'h00, 8'h00}, 1'b0, 1'b0, 0);

    repeat (6) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dut%0d_pl_left", k), 32'(exp_pl[k].size()), 32'(0));
      chk($sformatf("dut%0d_status_left", k), 32'(exp_st[k].size()), 32'(0));
`ifdef CRC16_RX_CHK_ERR_CNT_EN
      chk($sformatf("dut%0d_err_cnt", k), 32'(err_cnt[k]), 32'(tot_crc[k]));
`endif
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
